// File: rtl/simple_gan_generator.sv
// simple_gan_generator: two-layer FC generator (ReLU hidden, PWL tanh output) sharing one MAC.
// Weights/biases arrive from external ROMs one cycle after their address.
module simple_gan_tanh #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic                         valid_in,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         valid_out
);
    localparam int AW = DATA_WIDTH + 1;
    logic [AW-1:0]         mag_x;
    logic [DATA_WIDTH-1:0] mag_y;
    always_comb begin
        // one extra bit so that |-32768| is representable
        mag_x = x[DATA_WIDTH-1] ? AW'(-AW'(x)) : AW'(x);
        mag_y = mag_x < AW'(128) ? mag_x[DATA_WIDTH-1:0]
              : mag_x < AW'(384) ? DATA_WIDTH'(mag_x >> 1) + DATA_WIDTH'(64)
              : DATA_WIDTH'(255);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) y <= x[DATA_WIDTH-1] ? -mag_y : mag_y;
        end
    end
endmodule

module simple_gan_generator #(
    parameter int LATENT_DIM   = 2,
    parameter int HIDDEN_SIZE  = 3,
    parameter int OUTPUT_SIZE  = 9,
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [DATA_WIDTH-1:0]   latent_in [0:LATENT_DIM-1],
    input  logic                           valid_in,
    output logic signed [DATA_WIDTH-1:0]   gen_out [0:OUTPUT_SIZE-1],
    output logic                           valid_out,
    output logic                           done,
    output logic [3:0]                     w1_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] w1_data,
    output logic [1:0]                     b1_addr,
    input  logic signed [DATA_WIDTH-1:0]   b1_data,
    output logic [4:0]                     w2_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] w2_data,
    output logic [3:0]                     b2_addr,
    input  logic signed [DATA_WIDTH-1:0]   b2_data
);
    localparam int IW   = $clog2(LATENT_DIM + HIDDEN_SIZE + 1);
    localparam int OW   = $clog2(HIDDEN_SIZE + OUTPUT_SIZE + 1);
    localparam int MAXV = (1 << (DATA_WIDTH - 1)) - 1;
    localparam int MINV = -(1 << (DATA_WIDTH - 1));

    typedef enum logic [2:0] {IDLE, L1_MAC, L1_FIN, L2_MAC, L2_FIN, L2_TANH, DONE} state_t;
    state_t state, state_nx;

    logic [IW-1:0]                 in_idx, sel;
    logic [OW-1:0]                 out_idx;
    logic signed [31:0]            acc, prod, sum, shifted;
    logic signed [DATA_WIDTH-1:0]  latent_reg [0:LATENT_DIM-1];
    logic signed [DATA_WIDTH-1:0]  hidden [0:HIDDEN_SIZE-1];
    logic signed [DATA_WIDTH-1:0]  output_reg [0:OUTPUT_SIZE-1];
    logic signed [DATA_WIDTH-1:0]  a_op, bias, sat_val, tanh_in, tanh_y;
    logic signed [WEIGHT_WIDTH-1:0] w_op;
    logic                          is_l1, is_l2, fin, in_last, out_last, tanh_go, tanh_valid;
    logic [3:0]                    w1_hold, b2_hold;
    logic [1:0]                    b1_hold;
    logic [4:0]                    w2_hold;

    assign is_l1    = state == L1_MAC || state == L1_FIN;
    assign is_l2    = state == L2_MAC || state == L2_FIN || state == L2_TANH;
    assign fin      = state == L1_FIN || state == L2_FIN;
    assign in_last  = in_idx == (is_l1 ? IW'(LATENT_DIM - 1) : IW'(HIDDEN_SIZE - 1));
    assign out_last = out_idx == (is_l1 ? OW'(HIDDEN_SIZE - 1) : OW'(OUTPUT_SIZE - 1));
    // ROM data lags the address by a cycle, so the MAC works on the previous index
    assign sel      = fin ? (is_l1 ? IW'(LATENT_DIM - 1) : IW'(HIDDEN_SIZE - 1)) : in_idx - IW'(1);

    assign w1_addr = is_l1 ? 4'(32'(out_idx) * LATENT_DIM + 32'(in_idx)) : w1_hold;
    assign b1_addr = is_l1 ? 2'(out_idx) : b1_hold;
    assign w2_addr = is_l2 ? 5'(32'(out_idx) * HIDDEN_SIZE + 32'(in_idx)) : w2_hold;
    assign b2_addr = is_l2 ? 4'(out_idx) : b2_hold;

    assign gen_out   = output_reg;
    assign valid_out = state == DONE;
    assign done      = state == DONE;

    always_comb begin
        a_op = '0;
        for (int i = 0; i < LATENT_DIM; i++) if (is_l1 && 32'(sel) == i) a_op = latent_reg[i];
        for (int i = 0; i < HIDDEN_SIZE; i++) if (!is_l1 && 32'(sel) == i) a_op = hidden[i];
        w_op    = is_l1 ? w1_data : w2_data;
        bias    = is_l1 ? b1_data : b2_data;
        prod    = 32'(a_op) * 32'(w_op);
        sum     = acc + prod + (32'(bias) <<< 7);
        shifted = sum >>> 7;
        sat_val = shifted > MAXV ? DATA_WIDTH'(MAXV)
                : shifted < MINV ? DATA_WIDTH'(MINV) : shifted[DATA_WIDTH-1:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (valid_in) state_nx = L1_MAC;
            L1_MAC:  if (in_last) state_nx = L1_FIN;
            L1_FIN:  state_nx = out_last ? L2_MAC : L1_MAC;
            L2_MAC:  if (in_last) state_nx = L2_FIN;
            L2_FIN:  state_nx = L2_TANH;
            L2_TANH: if (tanh_valid) state_nx = out_last ? DONE : L2_MAC;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_idx  <= '0;
            out_idx <= '0;
            acc     <= '0;
            tanh_in <= '0;
            tanh_go <= 1'b0;
            w1_hold <= '0;
            b1_hold <= '0;
            w2_hold <= '0;
            b2_hold <= '0;
            for (int i = 0; i < LATENT_DIM; i++) latent_reg[i] <= '0;
            for (int i = 0; i < HIDDEN_SIZE; i++) hidden[i] <= '0;
            for (int i = 0; i < OUTPUT_SIZE; i++) output_reg[i] <= '0;
        end else begin
            tanh_go <= 1'b0;
            if (is_l1) begin
                w1_hold <= w1_addr;
                b1_hold <= b1_addr;
            end
            if (is_l2) begin
                w2_hold <= w2_addr;
                b2_hold <= b2_addr;
            end
            case (state)
                IDLE: if (valid_in) begin
                    for (int i = 0; i < LATENT_DIM; i++) latent_reg[i] <= latent_in[i];
                    in_idx  <= '0;
                    out_idx <= '0;
                    acc     <= '0;
                end
                L1_MAC, L2_MAC: begin
                    if (in_idx != '0) acc <= acc + prod;
                    in_idx <= in_last ? '0 : in_idx + IW'(1);
                end
                L1_FIN: begin
                    for (int i = 0; i < HIDDEN_SIZE; i++)
                        if (32'(out_idx) == i) hidden[i] <= sat_val[DATA_WIDTH-1] ? '0 : sat_val;
                    acc     <= '0;
                    out_idx <= out_last ? '0 : out_idx + OW'(1);
                end
                L2_FIN: begin
                    tanh_in <= sat_val;
                    tanh_go <= 1'b1;
                    acc     <= '0;
                end
                L2_TANH: if (tanh_valid) begin
                    for (int i = 0; i < OUTPUT_SIZE; i++)
                        if (32'(out_idx) == i) output_reg[i] <= tanh_y;
                    out_idx <= out_idx + OW'(1);
                end
                default: ;
            endcase
        end
    end

    simple_gan_tanh #(.DATA_WIDTH(DATA_WIDTH)) u_tanh (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (tanh_in),
        .valid_in  (tanh_go),
        .y         (tanh_y),
        .valid_out (tanh_valid)
    );
endmodule

// File: tb/tb_simple_gan_generator.sv
// tb_simple_gan_generator: directed + random runs of the generator against an arithmetic reference model.
module tb_simple_gan_generator;
    localparam int LD = 2, HS = 3, OS = 9, DW = 16, WW = 8;

    logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0;
    logic signed [DW-1:0] latent_in [0:LD-1];
    logic signed [DW-1:0] gen_out [0:OS-1];
    logic valid_out, done;
    logic [3:0] w1_addr, b2_addr;
    logic [1:0] b1_addr;
    logic [4:0] w2_addr;
    logic signed [WW-1:0] w1_data, w2_data;
    logic signed [DW-1:0] b1_data, b2_data;

    int w1_mem[16], b1_mem[4], w2_mem[32], b2_mem[16];
    int lat[LD], exp_q[OS];
    int w2_dir[9] = '{-6, -3, 6, 4, -2, 13, 46, 19, 9};
    int w1_dir[6] = '{7, 11, 23, 4, -29, -17};
    int tests = 0, fails = 0;

    simple_gan_generator dut (
        .clk(clk), .rst_n(rst_n), .latent_in(latent_in), .valid_in(valid_in),
        .gen_out(gen_out), .valid_out(valid_out), .done(done),
        .w1_addr(w1_addr), .w1_data(w1_data), .b1_addr(b1_addr), .b1_data(b1_data),
        .w2_addr(w2_addr), .w2_data(w2_data), .b2_addr(b2_addr), .b2_data(b2_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w1_data <= WW'(w1_mem[w1_addr]);
        b1_data <= DW'(b1_mem[b1_addr]);
        w2_data <= WW'(w2_mem[w2_addr]);
        b2_data <= DW'(b2_mem[b2_addr]);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(hi - lo));
    endfunction

    function automatic int floor128(input longint s);
        return int'(s >= 0 ? s / 128 : -((-s + 127) / 128));
    endfunction

    function automatic int clamp16(input int v);
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
    endfunction

    function automatic int tanh_ref(input int x);
        int a, y;
        a = x < 0 ? -x : x;
        y = a < 128 ? a : (a < 384 ? a / 2 + 64 : 255);
        return x < 0 ? -y : y;
    endfunction

    function automatic void model();
        int h[HS];
        longint s;
        for (int j = 0; j < HS; j++) begin
            s = longint'(b1_mem[j]) * 128;
            for (int i = 0; i < LD; i++) s += longint'(lat[i]) * w1_mem[j * LD + i];
            h[j] = clamp16(floor128(s));
            if (h[j] < 0) h[j] = 0;
        end
        for (int k = 0; k < OS; k++) begin
            s = longint'(b2_mem[k]) * 128;
            for (int i = 0; i < HS; i++) s += longint'(h[i]) * w2_mem[k * HS + i];
            exp_q[k] = tanh_ref(clamp16(floor128(s)));
        end
    endfunction

    task automatic check(input string tag, input int got, input int expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
        end
    endtask

    task automatic fill_random(input int lat_mag);
        for (int i = 0; i < LD * HS; i++) w1_mem[i] = rnd(-128, 127);
        for (int i = 0; i < HS; i++) b1_mem[i] = rnd(-512, 511);
        for (int i = 0; i < HS * OS; i++) w2_mem[i] = rnd(-128, 127);
        for (int i = 0; i < OS; i++) b2_mem[i] = rnd(-512, 511);
        for (int i = 0; i < LD; i++) lat[i] = rnd(-lat_mag, lat_mag - 1);
    endtask

    // Called at a negedge; returns at the negedge inside the done cycle.
    task automatic run(input string tag, input int poke_at);
        int e = 0;
        model();
        for (int i = 0; i < LD; i++) latent_in[i] = DW'(lat[i]);
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        while (e < 200) begin
            @(posedge clk);
            e++;
            #1 valid_in = (e == poke_at);
            if (e == poke_at) for (int i = 0; i < LD; i++) latent_in[i] = DW'($urandom);
            @(negedge clk);
            if (done) break;
        end
        check({tag, ".latency"}, e, 63);
        check({tag, ".valid_out"}, int'(valid_out), 1);
        for (int k = 0; k < OS; k++) check($sformatf("%s.gen_out[%0d]", tag, k), int'(gen_out[k]), exp_q[k]);
    endtask

    task automatic count_done(input string tag, input int cycles);
        int n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n++;
        end
        check(tag, n, 0);
    endtask

    initial begin
        for (int i = 0; i < LD; i++) latent_in[i] = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset.valid_out", int'(valid_out), 0);
        check("reset.done", int'(done), 0);
        for (int k = 0; k < OS; k++) check($sformatf("reset.gen_out[%0d]", k), int'(gen_out[k]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill_random(1024);
        foreach (w1_dir[i]) w1_mem[i] = w1_dir[i];
        foreach (w2_dir[i]) w2_mem[i] = w2_dir[i];
        for (int i = 0; i < HS; i++) b1_mem[i] = 0;
        for (int i = 0; i < OS; i++) b2_mem[i] = 0;
        lat[0] = 'h018B;
        lat[1] = 'h0016;
        run("directed", -1);
        check("directed.gen0", int'(gen_out[0]), -3);
        check("directed.gen1", int'(gen_out[1]), -1);
        check("directed.gen2", int'(gen_out[2]), 18);
        @(negedge clk);
        check("directed.single_pulse", int'(done), 0);

        fill_random(4096);
        run("b2b", -1);
        @(negedge clk);
        check("b2b.single_pulse", int'(done), 0);

        for (int i = 0; i < 32; i++) w2_mem[i] = 0;
        for (int i = 0; i < 16; i++) begin
            w1_mem[i] = 0;
            b2_mem[i] = 64 * i;
        end
        for (int i = 0; i < 4; i++) b1_mem[i] = 0;
        lat[0] = 0;
        lat[1] = 0;
        run("bias", -1);
        check("bias.gen2", int'(gen_out[2]), 128);
        check("bias.gen4", int'(gen_out[4]), 192);
        check("bias.gen8", int'(gen_out[8]), 255);
        @(negedge clk);

        for (int i = 0; i < LD * HS; i++) w1_mem[i] = -128;
        for (int i = 0; i < OS; i++) b2_mem[i] = -400;
        for (int i = 0; i < HS * OS; i++) w2_mem[i] = rnd(-128, 127);
        lat[0] = 'h7FFF;
        lat[1] = 'h7FFF;
        run("relu_neg", -1);
        check("relu_neg.gen0", int'(gen_out[0]), -255);
        @(negedge clk);

        for (int i = 0; i < LD * HS; i++) w1_mem[i] = 127;
        for (int i = 0; i < OS; i++) b2_mem[i] = 0;
        for (int i = 0; i < HS * OS; i++) w2_mem[i] = (i < HS * 4) ? -128 : 127;
        run("sat", -1);
        check("sat.gen0", int'(gen_out[0]), -255);
        check("sat.gen8", int'(gen_out[8]), 255);
        @(negedge clk);

        fill_random(2048);
        run("busy", 10);
        count_done("busy.extra_done", 70);

        fill_random(2048);
        for (int i = 0; i < LD; i++) latent_in[i] = DW'(lat[i]);
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.done", int'(done), 0);
        for (int k = 0; k < OS; k++) check($sformatf("abort.gen_out[%0d]", k), int'(gen_out[k]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_done("abort.no_done", 80);

        for (int r = 0; r < 6; r++) begin
            fill_random(r < 3 ? 1024 : 32768);
            run($sformatf("rand%0d", r), -1);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/simple_gan_generator.md
# simple_gan_generator

Two-layer fully-connected generator for the simpleGAN datapath. It maps a latent vector (Q8.8) through a ReLU hidden layer and a tanh output layer, producing OUTPUT_SIZE Q8.8 samples. Weights and biases come from external synchronous ROMs. Compute is sequential, using one shared multiply-accumulate unit.

## Interface
Module name: simple_gan_generator. One clock; reset is asynchronous and active-low.

Parameters:
- LATENT_DIM, default 2, number of latent inputs
- HIDDEN_SIZE, default 3, number of hidden neurons
- OUTPUT_SIZE, default 9, number of generator outputs
- DATA_WIDTH, default 16, activation and bias width (signed Q8.8)
- WEIGHT_WIDTH, default 8, weight width (signed Q1.7)

Ports:
- clk, input, 1, rising-edge clock
- rst_n, input, 1, asynchronous active-low reset
- latent_in[0:LATENT_DIM-1], input, DATA_WIDTH each, signed latent vector
- valid_in, input, 1, start request
- gen_out[0:OUTPUT_SIZE-1], output, DATA_WIDTH each, signed results; continuously driven from output registers
- valid_out, output, 1, one-cycle pulse when gen_out is complete
- done, output, 1, one-cycle pulse, identical timing to valid_out
- w1_addr, output, 4, layer-1 weight address = out_idx*LATENT_DIM + in_idx
- w1_data, input, WEIGHT_WIDTH, layer-1 weight, returned one cycle after address
- b1_addr, output, 2, layer-1 bias address = out_idx
- b1_data, input, DATA_WIDTH, layer-1 bias (Q8.8), returned one cycle after address
- w2_addr, output, 5, layer-2 weight address = out_idx*HIDDEN_SIZE + in_idx
- w2_data, input, WEIGHT_WIDTH, layer-2 weight, returned one cycle after address
- b2_addr, output, 4, layer-2 bias address = out_idx
- b2_data, input, DATA_WIDTH, layer-2 bias, returned one cycle after address

## Operation
- FSM states: IDLE, L1_MAC, L1_FIN, L2_MAC, L2_FIN, L2_TANH, DONE.
- IDLE:
  - On valid_in=1, latch latent_in into an internal register.
  - Clear out_idx, in_idx and the accumulator.
  - Go to L1_MAC.
  - valid_in is ignored in every other state.
- L1_MAC:
  - Issue w1_addr for in_idx = 0..LATENT_DIM-1, one per cycle.
  - Each cycle, accumulate the product of the previous cycle's w1_data and the matching latched latent.
  - After the last address, go to L1_FIN.
- L1_FIN:
  - sum = acc + last product + (b1_data <<< 7).
  - h = sum >>> 7 (arithmetic shift, floor), saturated to DATA_WIDTH.
  - Store hidden[out_idx] = max(h, 0) (ReLU).
  - Clear acc and increment out_idx.
  - Go back to L1_MAC, or to L2_MAC with out_idx=0 after HIDDEN_SIZE neurons.
- L2_MAC / L2_FIN:
  - Same structure as layer 1, using hidden[], w2 and b2, with no ReLU.
  - L2_FIN registers the saturated Q8.8 result into tanh_in and pulses the tanh unit's valid input.
- L2_TANH:
  - Wait for the tanh unit's valid_out, then write output_reg[out_idx] = tanh result.
  - Increment out_idx.
  - Go to L2_MAC, or to DONE after OUTPUT_SIZE outputs.
- DONE: assert valid_out=done=1 for exactly one cycle, then return to IDLE.
- Accumulator:
  - Signed, at least 32 bits.
  - Products are exact DATA_WIDTH x WEIGHT_WIDTH values (Q9.15).
  - No intermediate rounding.
- Saturation: results clamp to [-32768, 32767].
- Tanh unit:
  - Internal submodule with a registered output and 1-cycle valid-in to valid-out latency.
  - Piecewise-linear on a = |x| (Q8.8):
    - a < 128: y = a
    - 128 ≤ a < 384: y = (a >> 1) + 64
    - a ≥ 384: y = 255
  - The result takes the sign of x (y = -y for x < 0). Output range is ±255 (±0.996).
- Addresses for unused ROMs hold their last value. Address outputs are combinational from state and indices.

## Timing
- Reset values:
  - state = IDLE; all indices and the accumulator are 0.
  - hidden[] and output_reg[] are 0, so gen_out = 0.
  - valid_out = done = 0; tanh_in = 0.
- Per-neuron cost:
  - Hidden neuron: LATENT_DIM + 1 cycles.
  - Output neuron: HIDDEN_SIZE + 1 + 2 cycles.
- Latency with default parameters:
  - Let E0 be the edge that samples valid_in.
  - The state is DONE after E0 + 9 + 54 = E63.
  - done/valid_out are high for the single cycle between E63 and E64.
- gen_out is updated incrementally during layer 2. It is final only when valid_out=1, and holds stable until the next run's layer 2.
- A new run may start on the edge after DONE.
- Reset mid-run aborts immediately to the reset values. No pulse is emitted.

## Test plan
- Reset: hold rst_n=0 for 5 cycles -> gen_out all 0, valid_out=done=0, state IDLE.
- Directed compute run:
  - Stimulus: latent = [0x018B, 0x0016]; w1 = [7,11,23,4,-29,-17]; all biases 0; w2 as loaded for the simpleGAN generator, starting [-6,-3,6, 4,-2,13, 46,19,9, ...].
  - Required hidden = [23, 71, 0].
  - Required gen_out[0] = -3 (0xFFFD), gen_out[1] = -1 (0xFFFF), gen_out[2] = 18 (0x0012).
  - done pulses once, 63 cycles after the start edge.
- Bias path: latent 0, weights 0, b2[k] = 64·k -> gen_out[k] = tanh_pwl(64k), e.g. gen_out[2] = 128, gen_out[4] = 192, gen_out[8] = 255.
- Saturation and sign: drive large negative sums (weights -128, latent 0x7FFF) -> hidden clamps to 0 via ReLU; outputs driven to ≤ -384 give -255.
- Busy behavior: pulse valid_in again mid-run -> ignored, a single done pulse. Asserting rst_n low at cycle 20 -> outputs return to 0 and no done pulse.
- Back-to-back: restart on the cycle after done with a new latent -> the second result matches its model and done pulses again after 63 cycles.
